// File: rtl/shift_seq_8bit.sv
// Multi-cycle shift/rotate unit: one bit position per clock, start/busy/done handshake.
// Optional carry tracking is built only when SHIFT_SEQ_CARRY_EN is defined.
module shift_seq_8bit #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] i,
    input  logic [AMT_W-1:0] amt,
    input  logic             lr,
    input  logic             la,
    input  logic             rot,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] w_r;
    logic [AMT_W-1:0] cnt_r;
    logic             lr_r;
    logic             la_r;
    logic             rot_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] step_w_s;

    // One-position shift/rotate of the working value.
    function automatic logic [WIDTH-1:0] step_f(
        input logic [WIDTH-1:0] w,
        input logic             lr_v,
        input logic             la_v,
        input logic             rot_v
    );
        logic fill;
        if (lr_v) begin
            if (rot_v) begin
                fill = w[0];
            end else if (la_v) begin
                fill = w[WIDTH-1];
            end else begin
                fill = 1'b0;
            end
            step_f = {fill, w[WIDTH-1:1]};
        end else begin
            if (rot_v) begin
                fill = w[WIDTH-1];
            end else begin
                fill = 1'b0;
            end
            step_f = {w[WIDTH-2:0], fill};
        end
    endfunction

    // Next working value for the current step.
    always_comb begin
        step_w_s = step_f(w_r, lr_r, la_r, rot_r);
    end

`ifdef SHIFT_SEQ_CARRY_EN
    logic step_c_s;
    logic carry_r;

    // Bit leaving the working value on the current step.
    always_comb begin
        step_c_s = lr_r ? w_r[0] : w_r[WIDTH-1];
    end

    // Carry captured only when the result is published.
    always_ff @(posedge clk) begin
        if (rst) begin
            carry_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start && (amt == {AMT_W{1'b0}})) begin
                        carry_r <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (cnt_r == AMT_W'(1)) begin
                        carry_r <= step_c_s;
                    end
                end
                DONE:    carry_r <= carry_r;
                default: carry_r <= 1'b0;
            endcase
        end
    end

    assign carry_out = carry_r;
`else
    assign carry_out = 1'b0;
`endif

    // Sequencer: accept, step, publish. Result/done are loaded on entry to DONE
    // so they are valid together during the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            w_r      <= {WIDTH{1'b0}};
            cnt_r    <= {AMT_W{1'b0}};
            lr_r     <= 1'b0;
            la_r     <= 1'b0;
            rot_r    <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        w_r    <= i;
                        cnt_r  <= amt;
                        lr_r   <= lr;
                        la_r   <= la;
                        rot_r  <= rot;
                        busy_r <= 1'b1;
                        if (amt != {AMT_W{1'b0}}) begin
                            state_r <= SHIFT;
                        end else begin
                            state_r  <= DONE;
                            done_r   <= 1'b1;
                            result_r <= i;
                        end
                    end
                end
                SHIFT: begin
                    w_r   <= step_w_s;
                    cnt_r <= cnt_r - AMT_W'(1);
                    if (cnt_r == AMT_W'(1)) begin
                        state_r  <= DONE;
                        done_r   <= 1'b1;
                        result_r <= step_w_s;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

endmodule

// File: tb/tb_shift_seq_8bit.sv
// Directed + random bench for shift_seq_8bit with a done-side scoreboard.
// Carry expectations follow SHIFT_SEQ_CARRY_EN.
module tb_shift_seq_8bit;

    logic       clk = 1'b0;
    logic       rst, start, lr, la, rot;
    logic [7:0] i;
    logic [2:0] amt;
    logic       busy, done, carry_out;
    logic [7:0] result;

    typedef struct {
        logic [7:0] res;
        logic       c;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;

`ifdef SHIFT_SEQ_CARRY_EN
    localparam logic CEN = 1'b1;
`else
    localparam logic CEN = 1'b0;
`endif

    shift_seq_8bit dut (
        .clk(clk), .rst(rst), .start(start), .i(i), .amt(amt),
        .lr(lr), .la(la), .rot(rot), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: whole-amount shift expressed arithmetically.
    function automatic logic [8:0] model(input logic [7:0] v, input int a,
                                         input logic l, input logic ar, input logic r);
        logic [7:0] res;
        logic       c;
        if (a == 0) return {1'b0, v};
        if (r) begin
            if (!l) begin
                res = (v << a) | (v >> (8 - a));
                c = res[0];
            end else begin
                res = (v >> a) | (v << (8 - a));
                c = res[7];
            end
        end else if (!l) begin
            res = v << a;
            c = v[8 - a];
        end else begin
            if (ar) res = $signed(v) >>> a;
            else    res = v >> a;
            c = v[a - 1];
        end
        return {c & CEN, res};
    endfunction

    // Done-side monitor: pops the scoreboard and checks value and timing.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_result", {24'd0, result}, {24'd0, e.res});
                check("sb_carry", {31'd0, carry_out}, {31'd0, e.c});
                check("sb_latency", cyc, e.due);
            end
        end
    end

    task automatic start_op(input logic [7:0] v, input logic [2:0] a,
                            input logic l, input logic ar, input logic r);
        logic [8:0] m;
        exp_t e;
        @(negedge clk);
        i = v; amt = a; lr = l; la = ar; rot = r; start = 1'b1;
        busy_cnt = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        m = model(v, int'(a), l, ar, r);
        e.res = m[7:0];
        e.c   = m[8];
        e.due = cyc + int'(a);
        sb.push_back(e);
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 40 && busy; k++) @(negedge clk);
        check({tag, "_timeout"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int d0;
        rst = 1'b1; start = 1'b0; i = 8'h00; amt = 3'd0; lr = 1'b0; la = 1'b0; rot = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_carry", {31'd0, carry_out}, 32'd0);
        rst = 1'b0;

        d0 = done_cnt;
        start_op(8'hB4, 3'd3, 1'b1, 1'b1, 1'b0);
        wait_idle("t1");
        check("t1_result", {24'd0, result}, 32'h0000_00F6);
        check("t1_carry", {31'd0, carry_out}, {31'd0, CEN});
        check("t1_busy_cycles", busy_cnt, 32'd4);
        check("t1_done_count", done_cnt - d0, 32'd1);

        start_op(8'h81, 3'd1, 1'b0, 1'b0, 1'b1);
        wait_idle("t2");
        check("t2_result", {24'd0, result}, 32'h0000_0003);
        check("t2_carry", {31'd0, carry_out}, {31'd0, CEN});

        start_op(8'hFF, 3'd5, 1'b1, 1'b0, 1'b0);
        wait_idle("t3");
        check("t3_result", {24'd0, result}, 32'h0000_0007);
        check("t3_carry", {31'd0, carry_out}, {31'd0, CEN});
        check("t3_busy_cycles", busy_cnt, 32'd6);

        start_op(8'h5A, 3'd0, 1'b1, 1'b1, 1'b1);
        wait_idle("t4");
        check("t4_result", {24'd0, result}, 32'h0000_005A);
        check("t4_carry", {31'd0, carry_out}, 32'd0);
        check("t4_busy_cycles", busy_cnt, 32'd1);

        // Start pulse while shifting is dropped.
        d0 = done_cnt;
        start_op(8'hFF, 3'd5, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        i = 8'h00; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("t5");
        repeat (3) @(negedge clk);
        check("t5_result", {24'd0, result}, 32'h0000_0007);
        check("t5_done_count", done_cnt - d0, 32'd1);
        check("t5_busy_after", {31'd0, busy}, 32'd0);

        // Start held through the done cycle is dropped.
        d0 = done_cnt;
        start_op(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0);
        i = 8'h11; amt = 3'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        check("dc_busy_after", {31'd0, busy}, 32'd0);
        check("dc_done_count", done_cnt - d0, 32'd1);
        check("dc_result", {24'd0, result}, 32'h0000_005A);

        // Mid-operation reset aborts.
        d0 = done_cnt;
        start_op(8'h81, 3'd7, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_busy", {31'd0, busy}, 32'd0);
        check("t6_rst_done", {31'd0, done}, 32'd0);
        check("t6_rst_result", {24'd0, result}, 32'd0);
        check("t6_rst_carry", {31'd0, carry_out}, 32'd0);
        rst = 1'b0;
        sb.delete();
        repeat (10) @(negedge clk);
        check("t6_no_done", done_cnt - d0, 32'd0);
        start_op(8'h81, 3'd7, 1'b0, 1'b0, 1'b0);
        wait_idle("t6b");
        check("t6_result", {24'd0, result}, 32'h0000_0080);
        check("t6_carry", {31'd0, carry_out}, 32'd0);

        // Seven-position rotates in both directions.
        start_op(8'h01, 3'd7, 1'b1, 1'b0, 1'b1);
        wait_idle("rotr7");
        check("rotr7_result", {24'd0, result}, 32'h0000_0002);
        start_op(8'h03, 3'd7, 1'b0, 1'b1, 1'b1);
        wait_idle("rotl7");
        check("rotl7_result", {24'd0, result}, 32'h0000_0081);
        check("rotl7_carry", {31'd0, carry_out}, {31'd0, CEN});

        for (int n = 0; n < 24; n++) begin
            start_op(8'($urandom), 3'($urandom_range(7, 0)), 1'($urandom), 1'($urandom), 1'($urandom));
            wait_idle("rand");
        end

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
